// File: rtl/axi_dma_stream_writer.sv
// Streams 32-bit AXI-Stream words to memory as AXI4 INCR bursts, one burst in flight at a time.
// W beats pass straight through (wvalid=tvalid, tready=wready), so stream stalls track wready.
module axi_dma_stream_writer #(
  parameter int BURST_LEN  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           length,
  output logic                  busy,
  output logic                  done,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  localparam logic [16:0] LP_BURST     = 17'(BURST_LEN);
  localparam logic [7:0]  LP_MAX_AWLEN = 8'(BURST_LEN - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_remaining;
  logic [7:0]            r_awlen;
  logic [7:0]            r_beat_cnt;
  logic                  r_awvalid;
  logic                  r_bready;
  logic                  r_busy;
  logic                  r_done;

  logic [8:0]            w_burst_beats;
  logic [15:0]           w_rem_after_b;
  logic [ADDR_WIDTH-1:0] w_addr_after_b;
  logic                  w_in_w;
  logic                  w_w_fire;
  logic                  w_last_beat;

  // Full bursts until the tail, which carries whatever is left.
  function automatic logic [7:0] f_awlen(input logic [15:0] rem);
    if ({1'b0, rem} >= LP_BURST) return LP_MAX_AWLEN;
    return 8'(rem - 16'd1);
  endfunction

  assign w_burst_beats  = {1'b0, r_awlen} + 9'd1;
  assign w_rem_after_b  = r_remaining - {7'd0, w_burst_beats};
  assign w_addr_after_b = r_addr + ADDR_WIDTH'({w_burst_beats, 2'b00});
  assign w_in_w         = (r_state == S_W);
  assign w_w_fire       = w_in_w & s_axis_tvalid & m_axi_wready;
  assign w_last_beat    = (r_beat_cnt == r_awlen);

  assign busy          = r_busy;
  assign done          = r_done;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = w_in_w & s_axis_tvalid;
  assign m_axi_wlast   = w_in_w & w_last_beat;
  assign s_axis_tready = w_in_w & m_axi_wready;
  assign m_axi_bready  = r_bready;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_awlen     <= '0;
      r_beat_cnt  <= '0;
      r_awvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= length;
            r_busy      <= 1'b1;
            if (length == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_AW;
              r_awlen   <= f_awlen(length);
              r_awvalid <= 1'b1;
            end
          end
        end
        S_AW: begin
          if (m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_state   <= S_W;
          end
        end
        S_W: begin
          if (w_w_fire) begin
            if (w_last_beat) begin
              r_beat_cnt <= '0;
              r_bready   <= 1'b1;
              r_state    <= S_B;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            r_bready    <= 1'b0;
            r_remaining <= w_rem_after_b;
            r_addr      <= w_addr_after_b;
            if (w_rem_after_b != 16'd0) begin
              r_state   <= S_AW;
              r_awlen   <= f_awlen(w_rem_after_b);
              r_awvalid <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dma_stream_writer.sv
// Randomized bench for axi_dma_stream_writer: a job-level model predicts bursts, beats and done timing.
module tb_axi_dma_stream_writer;

  localparam int BL = 16;
  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          arstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [15:0]   length;
  logic          busy;
  logic          done;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [AW-1:0] m_axi_awaddr;
  logic [7:0]    m_axi_awlen;
  logic [2:0]    m_axi_awsize;
  logic [3:0]    m_axi_awcache;
  logic [2:0]    m_axi_awprot;
  logic          m_axi_awvalid;
  logic          m_axi_awready;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wlast;
  logic          m_axi_wvalid;
  logic          m_axi_wready;
  logic          m_axi_bvalid;
  logic          m_axi_bready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr[$];
  logic [7:0]  exp_len[$];
  bit          exp_last[$];
  logic [31:0] words[$];

  axi_dma_stream_writer #(.BURST_LEN(BL), .ADDR_WIDTH(AW)) u_dut (
    .aclk          (aclk),
    .arstn         (arstn),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awcache (m_axi_awcache),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  always #5 aclk = ~aclk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    start         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"},    32'(busy), 32'd0);
    chk({pfx, "_done"},    32'(done), 32'd0);
    chk({pfx, "_awvalid"}, 32'(m_axi_awvalid), 32'd0);
    chk({pfx, "_wvalid"},  32'(m_axi_wvalid), 32'd0);
    chk({pfx, "_wlast"},   32'(m_axi_wlast), 32'd0);
    chk({pfx, "_bready"},  32'(m_axi_bready), 32'd0);
    chk({pfx, "_tready"},  32'(s_axis_tready), 32'd0);
    chk({pfx, "_awaddr"},  m_axi_awaddr, 32'd0);
    chk({pfx, "_awlen"},   32'(m_axi_awlen), 32'd0);
  endtask

  // One job: build the expected burst list from the job rules, then act as stream source and AXI slave.
  task automatic run_job(input logic [31:0] base, input logic [15:0] len, input int aw_hold,
                         input int pa, input int pw, input int pv, input bit extra_start,
                         input int rst_beat);
    logic [31:0] a;
    int          rem, n;
    int          aw_i, beat, src_idx, cyc, hold_cnt, b_dly, done_cnt;
    bit          in_burst, b_pend, exp_done, cur_exp_done, fin, aw_pend_prev, ib, bp;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;

    exp_addr.delete(); exp_len.delete(); exp_last.delete(); words.delete();
    a   = base;
    rem = int'(len);
    while (rem > 0) begin
      n = (rem > BL) ? BL : rem;
      exp_addr.push_back(a);
      exp_len.push_back(8'(n - 1));
      for (int k = 0; k < n; k++) exp_last.push_back(k == n - 1);
      a   = a + 32'(n * 4);
      rem = rem - n;
    end
    for (int k = 0; k < int'(len); k++) words.push_back($urandom);

    @(posedge aclk); #1;
    drive_idle();
    start = 1'b1; base_addr = base; length = len;
    @(posedge aclk); #1;
    start = 1'b0; base_addr = $urandom; length = 16'($urandom);

    aw_i = 0; beat = 0; src_idx = 0; cyc = 0; hold_cnt = 0; b_dly = 0; done_cnt = 0;
    in_burst = 0; b_pend = 0; exp_done = (len == 16'd0); fin = 0; aw_pend_prev = 0;
    prev_addr = '0; prev_len = '0;

    while (!fin && cyc < 4000) begin
      m_axi_awready = m_axi_awvalid && (hold_cnt >= aw_hold) && ($urandom_range(0, 99) < pa);
      m_axi_wready  = ($urandom_range(0, 99) < pw);
      s_axis_tvalid = (src_idx < int'(len)) && ($urandom_range(0, 99) < pv);
      s_axis_tdata  = s_axis_tvalid ? words[src_idx] : $urandom;
      m_axi_bvalid  = b_pend && (b_dly == 0);
      start         = extra_start && (cyc == 5);
      if (start) begin
        base_addr = $urandom;
        length    = 16'($urandom_range(1, 100));
      end

      @(negedge aclk);
      ib = in_burst;
      bp = b_pend;

      if (rst_beat > 0 && ib && beat == rst_beat - 1) begin
        arstn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        drive_idle();
        return;
      end

      cur_exp_done = exp_done;
      exp_done     = 0;
      chk("done", 32'(done), 32'(cur_exp_done));
      chk("busy", 32'(busy), 32'd1);
      if (done) done_cnt++;
      if (cur_exp_done) fin = 1;

      if (!ib) begin
        chk("wvalid_idle", 32'(m_axi_wvalid), 32'd0);
        chk("tready_idle", 32'(s_axis_tready), 32'd0);
      end else begin
        chk("wvalid_tvalid", 32'(m_axi_wvalid), 32'(s_axis_tvalid));
        chk("tready_wready", 32'(s_axis_tready), 32'(m_axi_wready));
        if (m_axi_wvalid && m_axi_wready) begin
          if (beat < int'(len)) begin
            chk("wdata", m_axi_wdata, words[beat]);
            chk("wlast", 32'(m_axi_wlast), 32'(exp_last[beat]));
            chk("wstrb", 32'(m_axi_wstrb), 32'hF);
            if (exp_last[beat]) begin
              in_burst = 0;
              b_pend   = 1;
              b_dly    = $urandom_range(0, 3);
            end
            beat++;
          end else begin
            chk("w_unexpected", 32'(m_axi_wvalid), 32'd0);
          end
        end
      end
      if (s_axis_tvalid && s_axis_tready) src_idx++;

      chk("bready", 32'(m_axi_bready), 32'(bp));
      if (bp && m_axi_bvalid && m_axi_bready) begin
        b_pend = 0;
        if (aw_i == exp_addr.size()) exp_done = 1;
      end else if (bp && b_dly > 0) begin
        b_dly--;
      end

      if (m_axi_awvalid) begin
        chk("aw_one_outstanding", 32'(ib || bp), 32'd0);
        if (aw_pend_prev) begin
          chk("awaddr_stable", m_axi_awaddr, prev_addr);
          chk("awlen_stable", 32'(m_axi_awlen), 32'(prev_len));
        end
        if (aw_i >= exp_addr.size()) begin
          chk("aw_unexpected", 32'(m_axi_awvalid), 32'd0);
          aw_pend_prev = 0;
        end else if (m_axi_awready) begin
          chk("awaddr", m_axi_awaddr, exp_addr[aw_i]);
          chk("awlen", 32'(m_axi_awlen), 32'(exp_len[aw_i]));
          chk("awsize", 32'(m_axi_awsize), 32'd2);
          chk("awcache", 32'(m_axi_awcache), 32'd3);
          chk("awprot", 32'(m_axi_awprot), 32'd0);
          aw_i++;
          in_burst     = 1;
          hold_cnt     = 0;
          aw_pend_prev = 0;
        end else begin
          hold_cnt++;
          aw_pend_prev = 1;
          prev_addr    = m_axi_awaddr;
          prev_len     = m_axi_awlen;
        end
      end else begin
        if (aw_pend_prev) chk("awvalid_held", 32'(m_axi_awvalid), 32'd1);
        aw_pend_prev = 0;
      end

      cyc++;
      if (!fin) begin
        @(posedge aclk); #1;
      end
    end

    chk("job_completed", 32'(fin), 32'd1);
    chk("aw_total", 32'(aw_i), 32'(exp_addr.size()));
    chk("beats_total", 32'(beat), 32'(len));
    @(posedge aclk); #1;
    drive_idle();
    @(negedge aclk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_after_done", 32'(done), 32'd0);
    if (done) done_cnt++;
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    logic [31:0] rb;
    logic [15:0] rl;
    arstn     = 1'b0;
    base_addr = '0;
    length    = '0;
    drive_idle();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk_reset_outputs("reset");
    arstn = 1'b1;

    run_job(32'h1000_0000, 16'd32, 0, 100, 100, 100, 1'b0, 0);
    run_job(32'h1000_0000, 16'd20, 0, 100, 100, 100, 1'b0, 0);
    run_job(32'h2000_0000, 16'd0,  0, 100, 100, 100, 1'b0, 0);
    run_job(32'h3000_0400, 16'd40, 10, 60, 50, 60, 1'b0, 0);
    run_job(32'h4000_0000, 16'd32, 0, 80, 80, 80, 1'b1, 0);

    run_job(32'h1000_0000, 16'd32, 0, 100, 100, 100, 1'b0, 7);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    arstn = 1'b1;
    run_job(32'h5000_0000, 16'd4, 0, 100, 100, 100, 1'b0, 0);

    run_job(32'hFFFF_FFC0, 16'd32, 0, 70, 70, 70, 1'b0, 0);

    for (int j = 0; j < 6; j++) begin
      rb       = $urandom;
      rb[5:0]  = 6'd0;
      rl       = 16'($urandom_range(1, 70));
      run_job(rb, rl, $urandom_range(0, 3), $urandom_range(40, 100),
              $urandom_range(40, 100), $urandom_range(40, 100), 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
